// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: valid/ready command front-end for the 4-bit ALU datapath.
// Registers a command onto the ALU inputs, waits SETTLE_CYCLES clocks, captures
// f/CiOut and holds the result until the downstream handshake completes.
// Optional feature macro: ALU_SEQ_CHAIN_EN (cmd_chain selects the last result as A).
module alu_cmd_sequencer #(
   parameter int unsigned SETTLE_CYCLES = 2,  // legal range 1..15
   parameter int unsigned CNT_W         = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [3:0]       cmd_a,
   input  logic [3:0]       cmd_b,
   input  logic [2:0]       cmd_op,
   input  logic             cmd_chain,
   output logic [3:0]       A,
   output logic [3:0]       B,
   output logic             m,
   output logic             s1,
   output logic             s0,
   input  logic [3:0]       f,
   input  logic             CiOut,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [3:0]       res_f,
   output logic             res_cout,
   output logic [2:0]       res_op,
   output logic [CNT_W-1:0] op_count
);

   typedef enum logic [1:0] {StIdle, StSettle, StHold} state_e;

   localparam logic [3:0] SettleLast = 4'(SETTLE_CYCLES - 1);

   state_e           state_q, state_d;
   logic [3:0]       settle_cnt_q;
   logic [3:0]       a_q, b_q, res_f_q;
   logic [2:0]       op_q, res_op_q;
   logic             res_cout_q, res_valid_q;
   logic [CNT_W-1:0] op_count_q;
   logic [3:0]       a_in;
   logic             accept, capture, res_done;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= StIdle;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (cmd_valid) state_d = StSettle;
         StSettle: if (settle_cnt_q == SettleLast) state_d = StHold;
         StHold:   if (res_ready) state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // Handshake strobes; cmd_ready is forced low while reset is asserted
   always_comb begin
      cmd_ready = (state_q == StIdle) && !rst;
      accept    = cmd_ready && cmd_valid;
      capture   = (state_q == StSettle) && (settle_cnt_q == SettleLast);
      res_done  = (state_q == StHold) && res_ready;
   end

`ifdef ALU_SEQ_CHAIN_EN
   logic [3:0] last_f_q;

   // Last delivered result, reused as operand A for chained commands
   always_ff @(posedge clk) begin
      if (rst)           last_f_q <= '0;
      else if (res_done) last_f_q <= res_f_q;
   end

   assign a_in = cmd_chain ? last_f_q : cmd_a;
`else
   logic unused_chain;
   assign unused_chain = cmd_chain;
   assign a_in         = cmd_a;
`endif

   // ALU drive registers: load only on command acceptance
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= '0;
         res_op_q <= '0;
      end else if (accept) begin
         a_q      <= a_in;
         b_q      <= cmd_b;
         op_q     <= cmd_op;
         res_op_q <= cmd_op;
      end
   end

   // Settle counter: cleared on accept, counts while settling
   always_ff @(posedge clk) begin
      if (rst)                        settle_cnt_q <= '0;
      else if (accept)                settle_cnt_q <= '0;
      else if (state_q == StSettle)   settle_cnt_q <= settle_cnt_q + 4'd1;
   end

   // Result capture, valid flag and completed-operation counter
   always_ff @(posedge clk) begin
      if (rst) begin
         res_f_q     <= '0;
         res_cout_q  <= 1'b0;
         res_valid_q <= 1'b0;
         op_count_q  <= '0;
      end else if (capture) begin
         res_f_q     <= f;
         res_cout_q  <= CiOut;
         res_valid_q <= 1'b1;
      end else if (res_done) begin
         res_valid_q <= 1'b0;
         op_count_q  <= op_count_q + CNT_W'(1);
      end
   end

   assign A         = a_q;
   assign B         = b_q;
   assign m         = op_q[2];
   assign s1        = op_q[1];
   assign s0        = op_q[0];
   assign res_f     = res_f_q;
   assign res_cout  = res_cout_q;
   assign res_op    = res_op_q;
   assign res_valid = res_valid_q;
   assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer: directed sequences, an opcode table
// sweep and a randomized run scored against a queue-based reference model.
module tb_alu_cmd_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [3:0] cmd_a = '0, cmd_b = '0;
   logic [2:0] cmd_op = '0;
   logic       cmd_chain = 1'b0;
   logic [3:0] A, B;
   logic       m, s1, s0;
   logic [3:0] f;
   logic       CiOut;
   logic       res_valid;
   logic       res_ready = 1'b0;
   logic [3:0] res_f;
   logic       res_cout;
   logic [2:0] res_op;
   logic [7:0] op_count;

   int compared = 0;
   int mismatched = 0;
   int cyc = 0;

   alu_cmd_sequencer #(.SETTLE_CYCLES(2), .CNT_W(8)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_chain(cmd_chain),
      .A(A), .B(B), .m(m), .s1(s1), .s0(s0),
      .f(f), .CiOut(CiOut),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_f(res_f), .res_cout(res_cout), .res_op(res_op),
      .op_count(op_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Bench ALU: returns {carry, f}
   function automatic logic [4:0] alu_ref(input logic [3:0] a, input logic [3:0] b,
                                          input logic [2:0] op);
      case (op)
         3'd0:    return {1'b0, a} + {1'b0, b};
         3'd1:    return {1'b0, a} + {1'b0, ~b} + 5'd1;
         3'd2:    return {1'b0, a & b};
         3'd3:    return {1'b0, a | b};
         3'd4:    return {1'b0, a ^ b};
         3'd5:    return {1'b0, ~a};
         3'd6:    return {1'b0, a};
         default: return {1'b0, b};
      endcase
   endfunction

   assign {CiOut, f} = alu_ref(A, B, {m, s1, s0});

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      compared++;
      if (act !== want) begin
         mismatched++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, want, $time);
      end
   endtask

   // Reference model: queue of accepted commands and their expected results
   typedef struct {
      logic [3:0] f;
      logic       c;
      logic [2:0] op;
   } res_t;

   res_t       exp_q[$];
   res_t       e;
   int         m_count = 0;
   logic [3:0] m_last = '0;
   logic       drv_pending = 1'b0;
   logic [3:0] drv_a, drv_b, a_eff;
   logic [2:0] drv_op;
   logic [4:0] r;

   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         m_count     = 0;
         m_last      = '0;
         drv_pending = 1'b0;
      end else begin
         if (drv_pending) begin
            chk("drive A", A, drv_a);
            chk("drive B", B, drv_b);
            chk("drive op", {m, s1, s0}, drv_op);
            drv_pending = 1'b0;
         end
         if (res_valid && res_ready) begin
            if (exp_q.size() == 0) chk("unexpected result", res_valid, 0);
            else begin
               e = exp_q.pop_front();
               chk("model res_f", res_f, e.f);
               chk("model res_cout", res_cout, e.c);
               chk("model res_op", res_op, e.op);
               m_count++;
               m_last = e.f;
            end
         end
         if (cmd_valid && cmd_ready) begin
            a_eff = cmd_a;
`ifdef ALU_SEQ_CHAIN_EN
            if (cmd_chain) a_eff = m_last;
`endif
            r = alu_ref(a_eff, cmd_b, cmd_op);
            exp_q.push_back('{f: r[3:0], c: r[4], op: cmd_op});
            drv_a       = a_eff;
            drv_b       = cmd_b;
            drv_op      = cmd_op;
            drv_pending = 1'b1;
         end
      end
   end

   // Offer a command (called just after a rising edge); returns just after the accept edge
   task automatic send_cmd(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                           input logic chain);
      logic rdy;
      int   n;
      cmd_a = a; cmd_b = b; cmd_op = op; cmd_chain = chain; cmd_valid = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         rdy = cmd_ready;
         @(posedge clk);
         n++;
      end while (!rdy && n < 100);
      #1 cmd_valid = 1'b0;
      if (!rdy) chk("cmd_ready timeout", rdy, 1);
   endtask

   // Returns at the falling edge where res_valid is first seen high
   task automatic wait_res();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!res_valid && n < 100);
      if (!res_valid) chk("res_valid timeout", res_valid, 1);
   endtask

   task automatic ack(input int dly);
      repeat (dly) @(posedge clk);
      @(posedge clk);
      #1 res_ready = 1'b1;
      @(posedge clk);
      #1 res_ready = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 rst = 1'b1; cmd_valid = 1'b0; res_ready = 1'b0;
      @(negedge clk);
      chk("cmd_ready in reset", cmd_ready, 0);
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   typedef struct {
      logic [2:0] op;
      logic [3:0] f;
      logic       c;
   } vec_t;

   vec_t       tbl[8];
   int         t_res[8];
   logic [3:0] a_hold, b_hold, f_hold;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Sweep vectors for A=1010, B=0101
      tbl[0] = '{3'd0, 4'b1111, 1'b0};
      tbl[1] = '{3'd1, 4'b0101, 1'b1};
      tbl[2] = '{3'd2, 4'b0000, 1'b0};
      tbl[3] = '{3'd3, 4'b1111, 1'b0};
      tbl[4] = '{3'd4, 4'b1111, 1'b0};
      tbl[5] = '{3'd5, 4'b0101, 1'b0};
      tbl[6] = '{3'd6, 4'b1010, 1'b0};
      tbl[7] = '{3'd7, 4'b0101, 1'b0};

      // Power-on reset
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("cmd_ready in reset", cmd_ready, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset A", A, 0);
      chk("reset B", B, 0);
      chk("reset op", {m, s1, s0}, 0);
      chk("reset res_valid", res_valid, 0);
      chk("reset res_f", res_f, 0);
      chk("reset op_count", op_count, 0);
      chk("idle cmd_ready", cmd_ready, 1);

      // Basic operation
      @(posedge clk);
      #1;
      send_cmd(4'b0101, 4'b0100, 3'b000, 1'b0);
      @(negedge clk);
      chk("basic A", A, 4'b0101);
      chk("basic B", B, 4'b0100);
      chk("basic cmd_ready settle", cmd_ready, 0);
      @(negedge clk);
      chk("basic res_valid E1", res_valid, 0);
      @(negedge clk);
      chk("basic res_valid E2", res_valid, 1);
      chk("basic res_f", res_f, 4'b1001);
      chk("basic res_cout", res_cout, 0);
      chk("basic res_op", res_op, 3'b000);
      ack(0);
      @(negedge clk);
      chk("basic op_count", op_count, 1);
      chk("basic res_valid cleared", res_valid, 0);
      chk("basic cmd_ready idle", cmd_ready, 1);

      // Back-pressure
      @(posedge clk);
      #1;
      send_cmd(4'b0011, 4'b0110, 3'b000, 1'b0);
      wait_res();
      a_hold = A; b_hold = B; f_hold = res_f;
      chk("bp res_f", f_hold, 4'b1001);
      @(posedge clk);
      #1 cmd_a = 4'b1100; cmd_b = 4'b0001; cmd_op = 3'd4; cmd_chain = 1'b0; cmd_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bp cmd_ready", cmd_ready, 0);
         chk("bp A stable", A, a_hold);
         chk("bp B stable", B, b_hold);
         chk("bp res_f stable", res_f, f_hold);
         chk("bp res_valid", res_valid, 1);
      end
      @(posedge clk);
      #1 res_ready = 1'b1;
      @(posedge clk);
      #1 res_ready = 1'b0;
      @(negedge clk);
      chk("bp ready after handshake", cmd_ready, 1);
      chk("bp A before accept", A, a_hold);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      @(negedge clk);
      chk("bp second A", A, 4'b1100);
      chk("bp second B", B, 4'b0001);
      wait_res();
      chk("bp second res_f", res_f, 4'b1101);
      ack(0);

      // Opcode sweep with res_ready tied high
      do_reset();
      res_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         send_cmd(4'b1010, 4'b0101, tbl[i].op, 1'b0);
         @(negedge clk);
         chk("sweep op drive", {m, s1, s0}, tbl[i].op);
         wait_res();
         t_res[i] = cyc;
         chk("sweep res_f", res_f, tbl[i].f);
         chk("sweep res_cout", res_cout, tbl[i].c);
         @(posedge clk);
         #1;
      end
      res_ready = 1'b0;
      @(negedge clk);
      chk("sweep op_count", op_count, 8);
      for (int i = 1; i < 8; i++) chk("sweep spacing", t_res[i] - t_res[i-1], 4);

      // Reset one clock into SETTLE
      do_reset();
      send_cmd(4'b0111, 4'b0010, 3'd3, 1'b0);
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("midrst cmd_ready", cmd_ready, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("midrst A", A, 0);
      chk("midrst B", B, 0);
      chk("midrst op", {m, s1, s0}, 0);
      chk("midrst res_op", res_op, 0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("midrst res_valid", res_valid, 0);
         chk("midrst op_count", op_count, 0);
      end

      // Chaining
      @(posedge clk);
      #1;
      send_cmd(4'b0001, 4'b0010, 3'd0, 1'b0);
      wait_res();
      chk("chain first res_f", res_f, 4'b0011);
      ack(0);
      send_cmd(4'b1111, 4'b0000, 3'd0, 1'b1);
      @(negedge clk);
`ifdef ALU_SEQ_CHAIN_EN
      chk("chain A", A, 4'b0011);
`else
      chk("chain A", A, 4'b1111);
`endif
      wait_res();
      ack(0);

      // Randomized run of 256 handshakes: also exercises op_count wrap
      do_reset();
      for (int i = 0; i < 256; i++) begin
         send_cmd(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
         wait_res();
         ack($urandom_range(0, 2));
      end
      @(negedge clk);
      chk("wrap op_count", op_count, 0);
      chk("wrap queue empty", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
